// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: unsigned WIDTH-bit quotient and remainder,
// one quotient bit per clock, start/busy/done handshake.
// Q1/R1 are combinational golden outputs used only for comparison.
module seq_restoring_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] Q1,
   output logic [WIDTH-1:0] R1
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_dvd;   // dividend, shifted out MSB first
   logic [WIDTH-1:0] r_dvs;   // latched divisor
   logic [WIDTH-1:0] r_rem;   // partial remainder
   logic [WIDTH-1:0] r_quo;   // quotient bits collected so far
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_busy;
   logic             r_done;
   logic             r_dz;

   logic [WIDTH:0]   w_trial;
   logic [WIDTH:0]   w_diff;
   logic             w_neg;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;

   // One restoring iteration: trial subtract, keep difference or restore.
   // Partial remainder is always below the divisor, so the trial fits in
   // WIDTH+1 bits and a non-negative difference fits back in WIDTH bits.
   always_comb begin
      w_trial   = {r_rem, r_dvd[WIDTH-1]};
      w_diff    = w_trial - {1'b0, r_dvs};
      w_neg     = w_diff[WIDTH];
      w_rem_nxt = w_neg ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], ~w_neg};
   end

   // Control FSM with all datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_dvd  <= A;
                  r_dvs  <= B;
                  r_rem  <= '0;
                  r_quo  <= '0;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (B == '0) begin
                     // Divide by zero short-circuits straight to completion.
                     r_q     <= '1;
                     r_r     <= A;
                     r_dz    <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= StDone;
                  end else begin
                     r_dz    <= 1'b0;
                     r_state <= StRun;
                  end
               end
            end
            StRun: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
               r_cnt <= r_cnt + CntW'(1);
               if (r_cnt == LastCnt) begin
                  r_q     <= w_quo_nxt;
                  r_r     <= w_rem_nxt;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Golden reference outputs; B==0 values mirror the divide-by-zero result.
   always_comb begin
      if (B == '0) begin
         Q1 = '1;
         R1 = A;
      end else begin
         Q1 = A / B;
         R1 = A % B;
      end
   end

   assign Q        = r_q;
   assign R        = r_r;
   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_dz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] Q;
   logic [W-1:0] R;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] Q1;
   logic [W-1:0] R1;

   int n_err = 0;
   int n_chk = 0;
   bit chk_en = 1'b0;

   // Reference model state
   bit           m_busy = 1'b0;
   bit           m_done = 1'b0;
   bit           m_dz = 1'b0;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_r = '0;
   logic [W-1:0] p_q = '0;
   logic [W-1:0] p_r = '0;
   int           m_left = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .A        (A),
      .B        (B),
      .Q        (Q),
      .R        (R),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .Q1       (Q1),
      .R1       (R1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an accepted divide finishes WIDTH edges later (or at once for B==0),
   // done lasts one cycle, starts are ignored while an operation is in flight.
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_dz   = 1'b0;
         m_q    = '0;
         m_r    = '0;
         m_left = 0;
      end else if (m_done) begin
         m_done = 1'b0;
         m_busy = 1'b0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_q    = p_q;
            m_r    = p_r;
         end
      end else if (start) begin
         m_busy = 1'b1;
         if (B == 0) begin
            m_done = 1'b1;
            m_q    = '1;
            m_r    = A;
            m_dz   = 1'b1;
         end else begin
            m_dz   = 1'b0;
            m_left = W;
            p_q    = A / B;
            p_r    = A % B;
         end
      end
   end

   // Compare DUT against the model on every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("div_zero", div_zero, m_dz);
         chk("Q", Q, m_q);
         chk("R", R, m_r);
         if (B != 0) begin
            chk("Q1", Q1, A / B);
            chk("R1", R1, A % B);
         end
      end
   end

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input int elat, input string name,
                          input bit pin_model);
      int lat;
      @(posedge clk);
      #1;
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({name, " busy after start"}, busy, 1);
      if (b != 0) chk({name, " div_zero cleared"}, div_zero, 0);
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, " latency"}, lat, elat);
      chk({name, " Q"}, Q, eq);
      chk({name, " R"}, R, er);
      chk({name, " div_zero"}, div_zero, edz);
      if (pin_model) begin
         chk({name, " model Q"}, m_q, eq);
         chk({name, " model R"}, m_r, er);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;
      logic [W-1:0] held_q;
      logic [W-1:0] held_r;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rst = 1'b1;
      start = 1'b1;   // reset must win over start
      A = 8'd9;
      B = 8'd3;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset Q", Q, 0);
      chk("reset R", R, 0);
      chk("reset div_zero", div_zero, 0);
      rst = 1'b0;
      start = 1'b0;

      run_div(8'd255, 8'd15, 8'd17, 8'd0, 1'b0, 9, "255/15", 1'b1);
      run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, "200/7", 1'b1);
      run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, "5/9", 1'b1);
      run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, "255/1", 1'b1);
      run_div(8'd77, 8'd0, 8'd255, 8'd77, 1'b1, 1, "77/0", 1'b1);
      run_div(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9, "10/3", 1'b1);
      run_div(8'd0, 8'd1, 8'd0, 8'd0, 1'b0, 9, "0/1", 1'b1);
      run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, "255/255", 1'b1);
      run_div(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 9, "254/255", 1'b1);
      run_div(8'd128, 8'd2, 8'd64, 8'd0, 1'b0, 9, "128/2", 1'b1);

      // Inputs and start toggle during the operation; only the latched pair counts.
      @(posedge clk);
      #1;
      A = 8'd114;
      B = 8'd11;
      start = 1'b1;
      @(posedge clk);
      #1;
      ndone = 0;
      held_q = '0;
      held_r = '0;
      for (int k = 0; k < 13; k++) begin
         if (k < 9) begin
            A = W'($urandom);
            B = W'($urandom);
            start = ~k[0];
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            ndone++;
            held_q = Q;
            held_r = R;
         end
      end
      chk("disturbed done count", ndone, 1);
      chk("disturbed Q", held_q, 8'd10);
      chk("disturbed R", held_r, 8'd4);

      // Reset in the fourth RUN cycle aborts the divide.
      @(posedge clk);
      #1;
      A = 8'd191;
      B = 8'd19;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ndone = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) ndone++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
      rst = 1'b0;
      chk("abort done count", ndone, 0);
      chk("abort busy", busy, 0);
      chk("abort Q", Q, 0);
      chk("abort R", R, 0);
      run_div(8'd191, 8'd19, 8'd10, 8'd1, 1'b0, 9, "191/19", 1'b1);

      // Operand sweep with non-zero divisors.
      for (int i = 0; i < 2000; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(1, 255));
         run_div(ra, rb, ra / rb, ra % rb, 1'b0, 9, "sweep", 1'b0);
      end

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
